// File: rtl/serial_sub.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per clock, LSB digit first.
// The borrow between digits is kept in a register. Results are held until the next operation completes.

module serial_sub_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero,
    output logic             busy,
    output logic             done
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("serial_sub: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } opnd_t;

    state_t           state, state_nxt;
    opnd_t            opnd;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] res;

    logic [DIGIT:0]       bchain;
    logic [DIGIT-1:0]     dig;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]     res_nxt;
    logic                 last;
    logic                 ovf_nxt;

    // Ripple borrow chain across the bits of the current digit.
    assign bchain[0] = brw;
    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_bit
            serial_sub_bit u_bit (
                .a    (opnd.a[i]),
                .b    (opnd.b[i]),
                .bin  (bchain[i]),
                .d    (dig[i]),
                .bout (bchain[i+1])
            );
        end
    endgenerate

    // New digit enters from the MSB side; concatenation keeps DIGIT == WIDTH legal.
    assign res_cat = {dig, res};
    assign res_nxt = res_cat[WIDTH+DIGIT-1:DIGIT];
    assign last    = (cnt == CW'(NDIG - 1));
    assign ovf_nxt = bchain[DIGIT] ^ bchain[DIGIT-1];

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opnd <= '0;
            brw  <= 1'b0;
            cnt  <= '0;
            res  <= '0;
            diff <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opnd.a <= a;
                        opnd.b <= b;
                        brw    <= bin;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    opnd.a <= opnd.a >> DIGIT;
                    opnd.b <= opnd.b >> DIGIT;
                    res    <= res_nxt;
                    brw    <= bchain[DIGIT];
                    cnt    <= cnt + CW'(1);
                    // Visible outputs only move when the final digit lands.
                    if (last) begin
                        diff <= res_nxt;
                        bout <= bchain[DIGIT];
                        ovf  <= ovf_nxt;
                        zero <= (res_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Parametrised multi-cycle subtractor: computes `diff = a - b - bin` over WIDTH-bit operands.
- Processes DIGIT bits per clock, least-significant digit first, and ripples the borrow between digits in a register.
- Next generation of the team's single-bit full subtractor. It adds a start/done handshake, a borrow chain, and signed-overflow and zero flags.
- Used wherever wide subtraction must trade latency for area.

Parameters:
- WIDTH, 8, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 1, bits processed per clock; 1 <= DIGIT <= WIDTH. NDIG = WIDTH/DIGIT.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- bin  input  1  borrow-in; captured on the accepted start edge.
- diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
- bout  output  1  final borrow out of the MSB.
- ovf  output  1  signed overflow of the result.
- zero  output  1  high when diff == 0.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse marking a new valid result.

Behaviour:
- Reset: asynchronous; state=IDLE. diff, bout, ovf, zero, busy, done, digit counter, borrow register and operand shift registers are all 0. Takes effect immediately, including mid-operation; the in-flight result is discarded.
- States: IDLE, RUN, DONE. Moore outputs: busy=1 only in RUN; done=1 only in DONE.
- IDLE, start=1 at an edge:
  - latch a, b into shift registers and bin into the borrow register;
  - counter=0, go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each edge:
  - take the low DIGIT bits of each shift register;
  - compute {borrow_next, d} = a_dig - b_dig - borrow, at DIGIT+1 bits;
  - shift d into the result register from the MSB side;
  - shift the operand registers right by DIGIT; store borrow_next; counter++.
- RUN, on the edge that processes digit NDIG-1:
  - go to DONE;
  - register diff, bout = final borrow, zero = (diff == 0), ovf.
- ovf = 1 iff the signed value a - b - bin, with a and b two's complement, lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Equivalently, borrow into the MSB XOR borrow out of the MSB.
- DONE: lasts exactly one cycle, then goes to IDLE unconditionally.
- Latency: accepted start at edge E0; done is high from edge E0+NDIG to E0+NDIG+1.
- Result hold: diff, bout, ovf and zero are stable from edge E0+NDIG until the next accepted start completes. They do not change during the next RUN; output registers update only on entry to DONE.
- start while in RUN or DONE is ignored, with no queuing. a, b and bin may change freely after the capture edge.
- Back-to-back operation: start asserted in the IDLE cycle right after DONE is accepted. Minimum issue interval is NDIG+2 cycles.
- Degenerate case WIDTH=DIGIT=1: reproduces the full-subtractor truth table with latency 1.

Test Plan:
1. WIDTH=8, DIGIT=2; a=0x35, b=0x12, bin=0, start 1 cycle:
   - busy high 4 cycles; done 1 cycle at E0+4;
   - diff=0x23, bout=0, ovf=0, zero=0.
2. WIDTH=8, DIGIT=2, borrow and overflow cases:
   - a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0.
   - a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1.
   - a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, ovf=0.
3. WIDTH=8, DIGIT=2; a=0x05, b=0x05, bin=0:
   - diff=0x00, zero=1, bout=0.
   - Then a=0x05, b=0x04, bin=1 issued in the IDLE cycle after done -> accepted, diff=0x00, zero=1.
4. WIDTH=8, DIGIT=2; start held high continuously with changing a/b:
   - only the first value is accepted; the next is accepted in the IDLE cycle after done (period 6 cycles);
   - results held stable between done pulses.
5. Assert rst asynchronously, mid-clock, 2 cycles into RUN:
   - all outputs 0 immediately; no done pulse;
   - a following start with a=0x10, b=0x01 -> diff=0x0F after 4 cycles.
6. WIDTH=DIGIT=1, all 8 combinations of {a, b, bin}:
   - expected {diff, bout} = 00, 11, 11, 01, 10, 00, 00, 11;
   - done at E0+1 for each.
